// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes,
// multi-cycle multiply occupancy, memory-wait freeze and stall statistics.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   D_rs1, D_rs2             source register indices of the instruction in D
//   D_use_rs1, D_use_rs2     marks that the matching source is really read
//   EX_rd, EX_ld, EX_mul     destination / load / multiply flags of EX
//   EX_taken                 branch redirect raised by EX
//   mem_req, mem_ready       MEM-stage access handshake
//   hold_FD                  hold the PC and the F->D register
//   bubble_EX                insert a bubble into the D->EX register
//   flush_FD                 clear the F->D register
//   freeze                   hold the D->EX register and every later register
//   mul_busy, mul_done       multiply in progress / last multiply cycle
//   mem_timeout              sticky: memory wait lasted TIMEOUT cycles
//   stall_cycles             count of cycles with hold_FD asserted
module pipe_hazard_ctrl #(
    parameter int unsigned  MUL_LAT = 3,
    parameter logic [7:0]   TIMEOUT = 8'd200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  D_rs1,
    input  logic [4:0]  D_rs2,
    input  logic        D_use_rs1,
    input  logic        D_use_rs2,
    input  logic [4:0]  EX_rd,
    input  logic        EX_ld,
    input  logic        EX_mul,
    input  logic        EX_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        hold_FD,
    output logic        bubble_EX,
    output logic        flush_FD,
    output logic        freeze,
    output logic        mul_busy,
    output logic        mul_done,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles
);

    typedef enum logic {
        RUN,
        MUL_WAIT
    } state_t;

    // The RUN cycle that sees EX_mul and the final MUL_WAIT cycle both
    // count toward the latency, so the counter covers the remaining middle.
    localparam logic [3:0] MCNT_INIT = 4'(MUL_LAT - 2);

    state_t      state;
    state_t      state_next;
    logic [3:0]  mcnt;
    logic [3:0]  mcnt_next;
    logic [7:0]  mwcnt;
    logic [7:0]  mwcnt_next;
    logic        mem_wait;
    logic        load_use;
    logic        rs1_hit;
    logic        rs2_hit;

    assign mem_wait = mem_req && !mem_ready;
    assign rs1_hit  = D_use_rs1 && (D_rs1 == EX_rd);
    assign rs2_hit  = D_use_rs2 && (D_rs2 == EX_rd);
    assign load_use = EX_ld && (EX_rd != 5'd0) && (rs1_hit || rs2_hit);

    always_comb begin
        state_next = state;
        mcnt_next  = mcnt;
        freeze     = mem_wait;
        mul_busy   = 1'b0;
        mul_done   = 1'b0;
        unique case (state)
            RUN: begin
                if (EX_mul) begin
                    state_next = MUL_WAIT;
                    mcnt_next  = MCNT_INIT;
                    freeze     = 1'b1;
                end
            end
            MUL_WAIT: begin
                mul_busy = 1'b1;
                if (mcnt != 4'd0) begin
                    freeze = 1'b1;
                    if (!mem_wait) begin
                        mcnt_next = mcnt - 4'd1;
                    end
                end else if (!mem_wait) begin
                    // Result leaves EX this cycle; a following multiply
                    // is picked up again from RUN.
                    mul_done   = 1'b1;
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Freeze dominates; a taken branch discards the stalled instruction,
    // so it also cancels the load-use hold.
    assign bubble_EX = !freeze && (load_use || EX_taken);
    assign flush_FD  = !freeze && EX_taken;
    assign hold_FD   = freeze || (load_use && !EX_taken);

    always_comb begin
        mwcnt_next = 8'd0;
        if (mem_wait) begin
            mwcnt_next = (mwcnt == 8'hFF) ? mwcnt : mwcnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            mcnt         <= 4'd0;
            mwcnt        <= 8'd0;
            mem_timeout  <= 1'b0;
            stall_cycles <= 32'd0;
        end else begin
            state <= state_next;
            mcnt  <= mcnt_next;
            mwcnt <= mwcnt_next;
            if (mem_wait && (mwcnt_next == TIMEOUT)) begin
                mem_timeout <= 1'b1;
            end
            if (hold_FD) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios
// followed by randomized traffic, compared against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int         LAT = 3;
    localparam logic [7:0] TMO = 8'd4;

    logic        clk;
    logic        rst;
    logic [4:0]  D_rs1;
    logic [4:0]  D_rs2;
    logic        D_use_rs1;
    logic        D_use_rs2;
    logic [4:0]  EX_rd;
    logic        EX_ld;
    logic        EX_mul;
    logic        EX_taken;
    logic        mem_req;
    logic        mem_ready;
    logic        hold_FD;
    logic        bubble_EX;
    logic        flush_FD;
    logic        freeze;
    logic        mul_busy;
    logic        mul_done;
    logic        mem_timeout;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: multiply occupancy as "cycles still owed",
    // memory wait as a plain run length.
    bit          m_active;
    int          m_left;
    int          m_wait;
    bit          m_to;
    logic [31:0] m_stall;

    pipe_hazard_ctrl #(
        .MUL_LAT (LAT),
        .TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .D_rs1        (D_rs1),
        .D_rs2        (D_rs2),
        .D_use_rs1    (D_use_rs1),
        .D_use_rs2    (D_use_rs2),
        .EX_rd        (EX_rd),
        .EX_ld        (EX_ld),
        .EX_mul       (EX_mul),
        .EX_taken     (EX_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .hold_FD      (hold_FD),
        .bubble_EX    (bubble_EX),
        .flush_FD     (flush_FD),
        .freeze       (freeze),
        .mul_busy     (mul_busy),
        .mul_done     (mul_done),
        .mem_timeout  (mem_timeout),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        D_rs1 = 0; D_rs2 = 0; D_use_rs1 = 0; D_use_rs2 = 0;
        EX_rd = 0; EX_ld = 0; EX_mul = 0; EX_taken = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    // Check outputs against the model for the current inputs, then advance
    // the model and the clock by one cycle.
    task automatic cycle(input bit do_chk);
        bit mw, lu, start, frz, done, hold, bub, fl;
        #2;
        mw    = mem_req && !mem_ready;
        lu    = EX_ld && EX_rd != 0 &&
                ((D_use_rs1 && D_rs1 == EX_rd) ||
                 (D_use_rs2 && D_rs2 == EX_rd));
        start = !m_active && EX_mul;
        frz   = mw || start || (m_active && m_left > 1);
        done  = m_active && m_left == 1 && !mw;
        hold  = frz || (lu && !EX_taken);
        bub   = !frz && (lu || EX_taken);
        fl    = !frz && EX_taken;
        if (do_chk) begin
            chk("freeze", 32'(freeze), 32'(frz));
            chk("hold_FD", 32'(hold_FD), 32'(hold));
            chk("bubble_EX", 32'(bubble_EX), 32'(bub));
            chk("flush_FD", 32'(flush_FD), 32'(fl));
            chk("mul_busy", 32'(mul_busy), 32'(m_active));
            chk("mul_done", 32'(mul_done), 32'(done));
            chk("mem_timeout", 32'(mem_timeout), 32'(m_to));
            chk("stall_cycles", stall_cycles, m_stall);
        end
        if (rst) begin
            m_active = 0; m_left = 0; m_wait = 0; m_to = 0; m_stall = 0;
        end else begin
            if (start) begin
                m_active = 1;
                m_left   = LAT - 1;
            end else if (m_active && !mw) begin
                if (m_left == 1) m_active = 0;
                else m_left--;
            end
            if (hold) m_stall = m_stall + 1;
            if (mw) begin
                if (m_wait < 255) m_wait++;
                if (m_wait == int'(TMO)) m_to = 1;
            end else begin
                m_wait = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        cycle(0);
        cycle(0);
        rst = 0;
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        m_active = 0; m_left = 0; m_wait = 0; m_to = 0; m_stall = 0;
        do_reset();

        // Reset state with idle inputs.
        #2;
        chk("rst_hold", 32'(hold_FD), 0);
        chk("rst_freeze", 32'(freeze), 0);
        chk("rst_busy", 32'(mul_busy), 0);
        chk("rst_stall", stall_cycles, 0);
        cycle(1);

        // Load-use on rs1 stalls exactly one cycle.
        EX_ld = 1; EX_rd = 5; D_rs1 = 5; D_use_rs1 = 1;
        #2;
        chk("lu_hold", 32'(hold_FD), 1);
        chk("lu_bubble", 32'(bubble_EX), 1);
        cycle(1);
        clear_inputs();
        #2;
        chk("lu_stall_cnt", stall_cycles, 1);
        chk("lu_released", 32'(hold_FD), 0);
        cycle(1);

        // Exclusions: x0 destination, unused source.
        EX_ld = 1; EX_rd = 0; D_rs1 = 0; D_use_rs1 = 1;
        #2;
        chk("lu_x0", 32'(hold_FD), 0);
        cycle(1);
        EX_rd = 5; D_rs1 = 5; D_use_rs1 = 0;
        #2;
        chk("lu_unused", 32'(hold_FD), 0);
        cycle(1);
        EX_rd = 7; D_rs2 = 7; D_use_rs2 = 1;
        cycle(1);
        clear_inputs();

        // Multiply with LAT=3: freeze 0-1, done at 2, busy 1-2.
        EX_mul = 1;
        #2;
        chk("mul_c0_freeze", 32'(freeze), 1);
        chk("mul_c0_busy", 32'(mul_busy), 0);
        cycle(1);
        #2;
        chk("mul_c1_freeze", 32'(freeze), 1);
        chk("mul_c1_busy", 32'(mul_busy), 1);
        cycle(1);
        #2;
        chk("mul_c2_freeze", 32'(freeze), 0);
        chk("mul_c2_done", 32'(mul_done), 1);
        cycle(1);
        // Back-to-back multiply re-enters from RUN.
        #2;
        chk("mul_b2b_freeze", 32'(freeze), 1);
        chk("mul_b2b_busy", 32'(mul_busy), 0);
        cycle(1);
        cycle(1);
        cycle(1);
        clear_inputs();
        cycle(1);

        // Memory wait for 4 cycles while mcnt=1 holds the multiply.
        do_reset();
        EX_mul = 1;
        cycle(1);
        mem_req = 1; mem_ready = 0;
        repeat (4) cycle(1);
        mem_ready = 1;
        #2;
        chk("mw_mul_still_frozen", 32'(freeze), 1);
        cycle(1);
        #2;
        chk("mw_mul_done", 32'(mul_done), 1);
        cycle(1);
        clear_inputs();
        cycle(1);

        // Taken branch beats load-use; freeze beats both.
        EX_ld = 1; EX_rd = 3; D_rs2 = 3; D_use_rs2 = 1; EX_taken = 1;
        #2;
        chk("br_lu_bubble", 32'(bubble_EX), 1);
        chk("br_lu_flush", 32'(flush_FD), 1);
        chk("br_lu_hold", 32'(hold_FD), 0);
        cycle(1);
        mem_req = 1; mem_ready = 0;
        #2;
        chk("br_frz_bubble", 32'(bubble_EX), 0);
        chk("br_frz_flush", 32'(flush_FD), 0);
        cycle(1);
        mem_ready = 1;
        cycle(1);
        clear_inputs();

        // Timeout after 4 wait cycles, sticky until reset.
        do_reset();
        mem_req = 1; mem_ready = 0;
        repeat (3) cycle(1);
        #2;
        chk("tmo_not_yet", 32'(mem_timeout), 0);
        cycle(1);
        #2;
        chk("tmo_set", 32'(mem_timeout), 1);
        cycle(1);
        cycle(1);
        mem_ready = 1;
        cycle(1);
        #2;
        chk("tmo_sticky", 32'(mem_timeout), 1);
        cycle(1);
        rst = 1;
        cycle(1);
        rst = 0;
        #2;
        chk("tmo_cleared", 32'(mem_timeout), 0);
        cycle(1);

        // Reset mid-multiply returns to RUN without a done pulse.
        clear_inputs();
        EX_mul = 1;
        cycle(1);
        rst = 1;
        EX_mul = 0;
        cycle(1);
        rst = 0;
        #2;
        chk("rst_mul_busy", 32'(mul_busy), 0);
        chk("rst_mul_done", 32'(mul_done), 0);
        cycle(1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            D_rs1     = 5'($urandom_range(0, 7));
            D_rs2     = 5'($urandom_range(0, 7));
            D_use_rs1 = 1'($urandom_range(0, 1));
            D_use_rs2 = 1'($urandom_range(0, 1));
            EX_rd     = 5'($urandom_range(0, 7));
            EX_ld     = ($urandom_range(0, 2) == 0);
            EX_mul    = ($urandom_range(0, 5) == 0);
            EX_taken  = ($urandom_range(0, 4) == 0);
            mem_req   = 1'($urandom_range(0, 1));
            mem_ready = ($urandom_range(0, 9) < 6);
            cycle(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3, which sets the total cycles a multiply occupies EX; the legal range is 2..15.
REQ-002 SHALL have parameter TIMEOUT, default 8'd200, which sets the memory-wait cycle count at which the timeout flag sets.
REQ-003 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports D_rs1, D_rs2  in  5 each  source register indices of the instruction in D.
REQ-006 SHALL have ports D_use_rs1, D_use_rs2  in  1 each  marking that source as actually read.
REQ-007 SHALL have ports EX_rd (in, 5), EX_ld (in, 1) and EX_mul (in, 1), taken from the D->EX register outputs.
REQ-008 SHALL have port EX_taken  in  1  branch redirect from EX.
REQ-009 SHALL have ports mem_req and mem_ready  in  1 each  for the MEM-stage access handshake.
REQ-010 SHALL have output hold_FD  out  1  holding the PC and F->D register.
REQ-011 SHALL have output bubble_EX  out  1  driving stall_D of the D->EX register.
REQ-012 SHALL have output flush_FD  out  1  clearing the F->D register.
REQ-013 SHALL have output freeze  out  1  driving MEM_stall, i.e. holding the D->EX register and all later registers.
REQ-014 SHALL have outputs mul_busy (out, 1, high in MUL_WAIT) and mul_done (out, 1, one-cycle pulse at the last multiply cycle).
REQ-015 SHALL have outputs mem_timeout (out, 1, sticky) and stall_cycles (out, 32, performance counter).

Function
REQ-016 SHALL define mem_wait = mem_req && !mem_ready.
REQ-017 SHALL define load_use = EX_ld && EX_rd!=0 && ((D_use_rs1 && D_rs1==EX_rd) || (D_use_rs2 && D_rs2==EX_rd)).
REQ-018 SHALL implement an FSM with two states: RUN and MUL_WAIT.
REQ-019 SHALL keep a 4-bit counter mcnt.
REQ-020 SHALL transition RUN->MUL_WAIT when EX_mul=1 and load mcnt=MUL_LAT-2 on that transition.
REQ-021 SHALL decrement mcnt in MUL_WAIT only when mcnt!=0 and mem_wait=0.
REQ-022 SHALL return MUL_WAIT->RUN when mcnt==0 and mem_wait=0.
REQ-023 SHALL compute freeze combinationally as mem_wait || (RUN && EX_mul) || (MUL_WAIT && mcnt!=0).
REQ-024 SHALL make a multiply occupy EX for exactly MUL_LAT cycles when mem_wait stays low; a back-to-back multiply re-enters MUL_WAIT from the RUN cycle that follows.
REQ-025 SHALL assert mul_done combinationally in MUL_WAIT when mcnt==0 and mem_wait=0.
REQ-026 SHALL compute bubble_EX = !freeze && (load_use || EX_taken).
REQ-027 SHALL compute flush_FD = !freeze && EX_taken.
REQ-028 SHALL compute hold_FD = freeze || (load_use && !EX_taken).
REQ-029 SHALL give priority freeze > EX_taken > load_use when events coincide.
REQ-030 SHALL never assert bubble_EX or flush_FD while freeze=1; EX_taken held during a freeze takes effect in the first unfrozen cycle.
REQ-031 SHALL assert a load-use stall for exactly one cycle per hazard, since the inserted bubble clears EX_ld.
REQ-032 SHALL keep an 8-bit saturating counter mwcnt: it increments while mem_wait=1 and clears when mem_wait=0.
REQ-033 SHALL set mem_timeout on the cycle mwcnt reaches TIMEOUT; it holds until rst.
REQ-034 SHALL increment stall_cycles by 1 each cycle hold_FD=1; it wraps modulo 2^32.

Reset
REQ-035 SHALL, on rst=1 at a clock edge, set state=RUN, mcnt=0, mwcnt=0, mem_timeout=0 and stall_cycles=0, overriding all other updates.
REQ-036 SHALL, with registers at reset values and inputs at 0, drive hold_FD=0, bubble_EX=0, flush_FD=0, freeze=0, mul_busy=0 and mul_done=0.
REQ-037 SHALL, when rst is asserted mid-multiply, return to RUN on the next edge with mul_done never pulsing.

Verification
REQ-038 SHALL cover load-use: EX_ld=1, EX_rd=5, D_rs1=5, D_use_rs1=1 -> hold_FD=1 and bubble_EX=1 for 1 cycle; stall_cycles=1.
REQ-039 SHALL cover the load-use exclusions: EX_rd=0 or D_use_rs1=0 with an index match -> no stall.
REQ-040 SHALL cover MUL_LAT=3 with EX_mul=1 at cycle 0 -> freeze=1 for cycles 0-1, mul_done=1 and freeze=0 at cycle 2, mul_busy=1 for cycles 1-2.
REQ-041 SHALL cover mem_wait=1 for 4 cycles during MUL_WAIT with mcnt=1 -> mcnt holds, and freeze stays high 4 extra cycles.
REQ-042 SHALL cover EX_taken=1 together with load_use=1 -> bubble_EX=1, flush_FD=1, hold_FD=0; the same inputs with mem_wait=1 -> only freeze=1.
REQ-043 SHALL cover TIMEOUT=4 with mem_wait held 6 cycles -> mem_timeout rises on the 4th cycle and stays set after mem_ready; rst clears it.
